// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one 128-bit block memory between icache and dcache
//
// Purpose: round-robin arbiter with one block transaction in flight at a time.
//   The losing cache is stalled on its busywait. A watchdog aborts a transaction
//   that the memory never completes and raises a sticky timeout flag.
// Ports:
//   clock, reset (async, active-low)
//   ic_mem_read / ic_mem_address           -> icache read request
//   ic_mem_readdata / ic_mem_busywait      <- icache block and stall
//   dc_mem_read / dc_mem_write / dc_mem_address / dc_mem_writedata -> dcache request
//   dc_mem_readdata / dc_mem_busywait      <- dcache block and stall
//   mem_read / mem_write / mem_address / mem_writedata -> memory
//   mem_readdata / mem_busywait            <- memory
//   timeout                                <- sticky watchdog flag
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ic_mem_read,
  input  logic [27:0]  ic_mem_address,
  output logic [127:0] ic_mem_readdata,
  output logic         ic_mem_busywait,
  input  logic         dc_mem_read,
  input  logic         dc_mem_write,
  input  logic [27:0]  dc_mem_address,
  input  logic [127:0] dc_mem_writedata,
  output logic [127:0] dc_mem_readdata,
  output logic         dc_mem_busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic         timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_IC, G_DC} grant_t;

  state_t         r_state,         w_state_n;
  grant_t         r_grant,         w_grant_n;
  logic           r_last_dc,       w_last_dc_n;
  logic           r_mem_read,      w_mem_read_n;
  logic           r_mem_write,     w_mem_write_n;
  logic [27:0]    r_mem_address,   w_mem_address_n;
  logic [127:0]   r_mem_writedata, w_mem_writedata_n;
  logic [127:0]   r_rd_buf,        w_rd_buf_n;
  logic [CNT_W-1:0] r_cnt,         w_cnt_n;
  logic           r_timeout,       w_timeout_n;

  logic w_ic_req;
  logic w_dc_req;
  logic w_expire;
  logic w_pick_dc;

  assign w_ic_req = ic_mem_read;
  assign w_dc_req = dc_mem_read | dc_mem_write;
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Busywait drops only during the single RESP cycle of the granted requester.
  assign ic_mem_busywait = w_ic_req & ~((r_state == S_RESP) && (r_grant == G_IC));
  assign dc_mem_busywait = w_dc_req & ~((r_state == S_RESP) && (r_grant == G_DC));

  assign ic_mem_readdata = r_rd_buf;
  assign dc_mem_readdata = r_rd_buf;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_writedata   = r_mem_writedata;
  assign timeout         = r_timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_grant         <= G_NONE;
      r_last_dc       <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_rd_buf        <= '0;
      r_cnt           <= '0;
      r_timeout       <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_grant         <= w_grant_n;
      r_last_dc       <= w_last_dc_n;
      r_mem_read      <= w_mem_read_n;
      r_mem_write     <= w_mem_write_n;
      r_mem_address   <= w_mem_address_n;
      r_mem_writedata <= w_mem_writedata_n;
      r_rd_buf        <= w_rd_buf_n;
      r_cnt           <= w_cnt_n;
      r_timeout       <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n         = r_state;
    w_grant_n         = r_grant;
    w_last_dc_n       = r_last_dc;
    w_mem_read_n      = r_mem_read;
    w_mem_write_n     = r_mem_write;
    w_mem_address_n   = r_mem_address;
    w_mem_writedata_n = r_mem_writedata;
    w_rd_buf_n        = r_rd_buf;
    w_cnt_n           = r_cnt;
    w_timeout_n       = r_timeout;
    w_pick_dc         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_ic_req || w_dc_req) begin
          // On contention the requester that was not served last wins.
          w_pick_dc = w_dc_req && (!w_ic_req || !r_last_dc);
          if (w_pick_dc) begin
            w_grant_n         = G_DC;
            w_mem_address_n   = dc_mem_address;
            w_mem_writedata_n = dc_mem_writedata;
            // A write-back takes precedence when both dcache strobes are set.
            w_mem_write_n     = dc_mem_write;
            w_mem_read_n      = ~dc_mem_write;
          end else begin
            w_grant_n         = G_IC;
            w_mem_address_n   = ic_mem_address;
            w_mem_write_n     = 1'b0;
            w_mem_read_n      = 1'b1;
          end
          w_cnt_n   = '0;
          w_state_n = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (w_expire) begin
          w_timeout_n   = 1'b1;
          w_mem_read_n  = 1'b0;
          w_mem_write_n = 1'b0;
          w_state_n     = S_RESP;
        end else begin
          // The watchdog counts every cycle spent in ISSUE and WAIT.
          w_cnt_n = r_cnt + CNT_W'(1);
          if (mem_busywait) begin
            w_state_n = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!mem_busywait) begin
          if (r_mem_read) begin
            w_rd_buf_n = mem_readdata;
          end
          w_mem_read_n  = 1'b0;
          w_mem_write_n = 1'b0;
          w_state_n     = S_RESP;
        end else if (w_expire) begin
          w_timeout_n   = 1'b1;
          w_mem_read_n  = 1'b0;
          w_mem_write_n = 1'b0;
          w_state_n     = S_RESP;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        w_last_dc_n = (r_grant == G_DC);
        w_grant_n   = G_NONE;
        w_state_n   = S_IDLE;
      end

      default: begin
        w_state_n = S_IDLE;
        w_grant_n = G_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ic_mem_read = 1'b0;
  logic [27:0]  ic_mem_address = '0;
  logic [127:0] ic_mem_readdata;
  logic         ic_mem_busywait;
  logic         dc_mem_read = 1'b0;
  logic         dc_mem_write = 1'b0;
  logic [27:0]  dc_mem_address = '0;
  logic [127:0] dc_mem_writedata = '0;
  logic [127:0] dc_mem_readdata;
  logic         dc_mem_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic         timeout;

  int n_vec  = 0;
  int n_miss = 0;

  memory_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .ic_mem_read      (ic_mem_read),
    .ic_mem_address   (ic_mem_address),
    .ic_mem_readdata  (ic_mem_readdata),
    .ic_mem_busywait  (ic_mem_busywait),
    .dc_mem_read      (dc_mem_read),
    .dc_mem_write     (dc_mem_write),
    .dc_mem_address   (dc_mem_address),
    .dc_mem_writedata (dc_mem_writedata),
    .dc_mem_readdata  (dc_mem_readdata),
    .dc_mem_busywait  (dc_mem_busywait),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata),
    .mem_busywait     (mem_busywait),
    .timeout          (timeout)
  );

  always #5 clock = ~clock;

  // Memory model: accepts a strobe when idle, stays busy m_lat cycles
  // (forever while m_hang), then waits for the strobes to drop.
  int           m_lat  = 4;
  logic         m_hang = 1'b0;
  logic [127:0] m_data = '0;
  logic [1:0]   m_st   = 2'd0;
  int           m_cnt  = 0;
  logic         m_busy = 1'b0;
  logic [127:0] m_rdata = '0;
  logic [27:0]  log_addr[$];
  logic         log_wr[$];
  logic [127:0] log_wdata[$];

  assign mem_busywait = m_busy;
  assign mem_readdata = m_rdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_st   <= 2'd0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else begin
      case (m_st)
        2'd0: if (mem_read || mem_write) begin
          m_busy <= 1'b1;
          m_cnt  <= m_lat;
          m_st   <= 2'd1;
          log_addr.push_back(mem_address);
          log_wr.push_back(mem_write);
          log_wdata.push_back(mem_writedata);
        end
        2'd1: if (!m_hang) begin
          if (m_cnt <= 1) begin
            m_busy  <= 1'b0;
            m_rdata <= m_data;
            m_st    <= 2'd2;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        default: if (!(mem_read || mem_write)) m_st <= 2'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts posedges from the request edge until busywait is seen low at a negedge.
  task automatic wait_rel(input bit is_dc, input int limit, output int cyc, output bit saw_rd);
    bit done;
    done = 1'b0;
    cyc = 0;
    saw_rd = 1'b0;
    while (!done && cyc < limit) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (mem_read) saw_rd = 1'b1;
      if (!(is_dc ? dc_mem_busywait : ic_mem_busywait)) done = 1'b1;
    end
  endtask

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_WB = 128'h123456789ABCDEF0_0FEDCBA987654321;
  localparam logic [127:0] D_5A = {16{8'h5A}};
  localparam logic [127:0] D_C3 = {16{8'hC3}};

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int  cyc;
    bit  saw_rd;
    bit  ic_low_early;
    bit  done;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_mem_read", 128'(mem_read), 128'(0));
    check_eq("rst_mem_write", 128'(mem_write), 128'(0));
    check_eq("rst_mem_address", 128'(mem_address), 128'(0));
    check_eq("rst_mem_writedata", mem_writedata, 128'(0));
    check_eq("rst_readdata", ic_mem_readdata, 128'(0));
    check_eq("rst_timeout", 128'(timeout), 128'(0));
    check_eq("rst_busywaits", 128'({ic_mem_busywait, dc_mem_busywait}), 128'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // IC read, memory busy 4 cycles
    m_lat = 4; m_data = D_A5;
    ic_mem_address = 28'h0000010; ic_mem_read = 1'b1;
    wait_rel(1'b0, 40, cyc, saw_rd);
    check_eq("ic_rd_latency", 128'(cyc), 128'(7));
    check_eq("ic_rd_data", ic_mem_readdata, D_A5);
    check_eq("ic_rd_dc_idle", 128'(dc_mem_busywait), 128'(0));
    check_eq("ic_rd_log_addr", 128'(log_addr[0]), 128'(28'h0000010));
    check_eq("ic_rd_log_wr", 128'(log_wr[0]), 128'(0));
    ic_mem_read = 1'b0;
    @(negedge clock);
    check_eq("ic_rd_after_bw", 128'(ic_mem_busywait), 128'(0));
    check_eq("ic_rd_after_strobe", 128'(mem_read), 128'(0));

    // DC write-back with both dc strobes set: write wins, rd_buf untouched
    log_addr.delete(); log_wr.delete(); log_wdata.delete();
    m_lat = 3; m_data = 128'hDEAD;
    dc_mem_address = 28'h0000020; dc_mem_writedata = D_WB;
    dc_mem_read = 1'b1; dc_mem_write = 1'b1;
    wait_rel(1'b1, 40, cyc, saw_rd);
    check_eq("dc_wr_latency", 128'(cyc), 128'(6));
    check_eq("dc_wr_no_read", 128'(saw_rd), 128'(0));
    check_eq("dc_wr_log_addr", 128'(log_addr[0]), 128'(28'h0000020));
    check_eq("dc_wr_log_wr", 128'(log_wr[0]), 128'(1));
    check_eq("dc_wr_log_data", log_wdata[0], D_WB);
    check_eq("dc_wr_rdbuf_kept", dc_mem_readdata, D_A5);
    dc_mem_read = 1'b0; dc_mem_write = 1'b0;
    @(negedge clock);
    check_eq("hold_mem_address", 128'(mem_address), 128'(28'h0000020));
    check_eq("hold_mem_writedata", mem_writedata, D_WB);

    // Watchdog: memory never completes
    m_lat = 4; m_hang = 1'b1; m_data = 128'hBAD;
    ic_mem_address = 28'h0000060; ic_mem_read = 1'b1;
    @(posedge clock);
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      if (timeout) done = 1'b1;
      else begin
        @(posedge clock);
        cyc++;
      end
    end
    check_eq("wd_cycles", 128'(cyc), 128'(8));
    check_eq("wd_released", 128'(ic_mem_busywait), 128'(0));
    check_eq("wd_strobe_dropped", 128'(mem_read), 128'(0));
    check_eq("wd_rdbuf_kept", ic_mem_readdata, D_A5);
    ic_mem_read = 1'b0;
    m_hang = 1'b0;
    repeat (15) @(negedge clock);
    m_lat = 2; m_data = D_5A;
    ic_mem_address = 28'h0000070; ic_mem_read = 1'b1;
    wait_rel(1'b0, 40, cyc, saw_rd);
    check_eq("wd_next_latency", 128'(cyc), 128'(5));
    check_eq("wd_next_data", ic_mem_readdata, D_5A);
    check_eq("wd_sticky", 128'(timeout), 128'(1));
    ic_mem_read = 1'b0;
    @(negedge clock);

    // Reset mid-WAIT drops strobes immediately
    m_lat = 6;
    ic_mem_address = 28'h0000030; ic_mem_read = 1'b1;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_strobes", 128'({mem_read, mem_write}), 128'(0));
    check_eq("mid_rst_timeout", 128'(timeout), 128'(0));
    check_eq("mid_rst_ic_bw", 128'(ic_mem_busywait), 128'(1));
    check_eq("mid_rst_dc_bw", 128'(dc_mem_busywait), 128'(0));
    ic_mem_read = 1'b0;
    #1;
    check_eq("mid_rst_ic_bw_drop", 128'(ic_mem_busywait), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Contention after reset: DC first, then alternation
    log_addr.delete(); log_wr.delete(); log_wdata.delete();
    m_lat = 3; m_data = D_C3;
    ic_mem_address = 28'h0000050; ic_mem_read = 1'b1;
    dc_mem_address = 28'h0000040; dc_mem_read = 1'b1;
    ic_low_early = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (!dc_mem_busywait) done = 1'b1;
      else if (!ic_mem_busywait) ic_low_early = 1'b1;
    end
    check_eq("arb_dc_first_rel", 128'(done), 128'(1));
    check_eq("arb_ic_stalled", 128'(ic_low_early), 128'(0));
    check_eq("arb_ic_bw_at_dc_resp", 128'(ic_mem_busywait), 128'(1));
    check_eq("arb_dc_data", dc_mem_readdata, D_C3);
    cyc = 0;
    while (log_addr.size() < 4 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    ic_mem_read = 1'b0; dc_mem_read = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("arb_count", 128'(log_addr.size() >= 4), 128'(1));
    if (log_addr.size() >= 4) begin
      check_eq("arb_grant0", 128'(log_addr[0]), 128'(28'h0000040));
      check_eq("arb_grant1", 128'(log_addr[1]), 128'(28'h0000050));
      check_eq("arb_grant2", 128'(log_addr[2]), 128'(28'h0000040));
      check_eq("arb_grant3", 128'(log_addr[3]), 128'(28'h0000050));
    end
    check_eq("arb_idle_bw", 128'({ic_mem_busywait, dc_mem_busywait}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
